baud_gen_frac: RTL and testbench
================================

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 SHALL have parameter DIV_W, default 16, meaning width of integer divisor and bit counters.
REQ-002 SHALL have parameter FRAC_W, default 4, meaning width of fractional divisor and phase accumulator.
REQ-003 SHALL have parameter RESET_DIV, default 868, meaning integer divisor after reset (100 MHz / 115200).
REQ-004 SHALL have parameter RESET_FRAC, default 0, meaning fractional divisor after reset.
REQ-005 SHALL have port: clk  in  1  single clock; all logic rising-edge.
REQ-006 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port: div_int  in  DIV_W  integer divisor, clk cycles per bit.
REQ-008 SHALL have port: div_frac  in  FRAC_W  fractional divisor, units of 1/2^FRAC_W cycle.
REQ-009 SHALL have port: div_load  in  1  strobe; captures div_int/div_frac into shadow register.
REQ-010 SHALL have port: cfg_err  out  1  sticky: last div_load was rejected.
REQ-011 SHALL have ports: tx_init, rx_init  in  1 each  per-channel phase/divisor initialise.
REQ-012 SHALL have ports: tx_en, rx_en  in  1 each  per-channel count enable.
REQ-013 SHALL have ports: tx_tick, rx_tick  out  1 each  registered one-cycle bit pulses.

Function
REQ-014 SHALL contain two independent channels (tx, rx), each holding count[DIV_W], acc[FRAC_W], active divisor (int, frac), and a registered tick.
REQ-015 SHALL accept div_load only when div_int >= 2: shadow <= {div_int, div_frac}, cfg_err <= 0 next cycle.
REQ-016 SHALL on div_load with div_int < 2: shadow unchanged, cfg_err <= 1 next cycle, held until next accepted load or rst.
REQ-017 SHALL copy shadow into a channel's active divisor only on that channel's init; running channels are unaffected by div_load.
REQ-018 SHALL, when div_load (accepted) and init coincide in the same cycle, load the new div_int/div_frac directly into the channel's active divisor (load-through).
REQ-019 SHALL on tx_init: count <= 0, acc <= 0, tx_tick <= 0.
REQ-020 SHALL on rx_init: count <= active_int >> 1 (using the newly loaded divisor), acc <= 0, rx_tick <= 0.
REQ-021 SHALL give init priority over en; init with en high performs init only, no count.
REQ-022 SHALL, when en = 0 and no init: count and acc hold, tick <= 0.
REQ-023 SHALL define per-period target P = active_int + c, where c = carry-out of (acc + active_frac) in FRAC_W+1 bits.
REQ-024 SHALL, when en = 1 and count == P-1: count <= 0, acc <= (acc + active_frac) mod 2^FRAC_W, tick <= 1.
REQ-025 SHALL, when en = 1 and count != P-1: count <= count + 1, tick <= 0.
REQ-026 SHALL thereby produce an average period of active_int + active_frac/2^FRAC_W cycles, with each period being floor or ceil of that value.
REQ-027 SHALL never let count exceed P-1; if count > P-1 (not reachable through legal use), treat it as the wrap condition.
REQ-028 SHALL assert tx_tick in the cycle after the edge on which tx count == P-1 (registered output, one cycle wide).
REQ-029 SHALL keep channels fully independent; simultaneous tx/rx init, en, or tick events do not interact.
REQ-030 SHALL be synthesizable with no multipliers or dividers; the only arithmetic is adders, comparators and one shift.

Reset
REQ-031 SHALL on rst: shadow and both active divisors <= {RESET_DIV, RESET_FRAC}; counts, accs <= 0; tx_tick, rx_tick, cfg_err <= 0.
REQ-032 SHALL give rst priority over init, div_load and en, including mid-period; the first enabled cycle after rst behaves as after tx_init.

Verification
REQ-033 SHALL check: rst, div_load int=10 frac=0, tx_init, tx_en=1 held -> tx_tick pulses every 10 cycles, first 10 cycles after init.
REQ-034 SHALL check: div int=10 frac=8 (FRAC_W=4), tx run for 32 ticks -> periods alternate 10,11 and total 336 cycles.
REQ-035 SHALL check: div int=10, rx_init, rx_en=1 -> first rx_tick 5 cycles after init, then every 10 cycles.
REQ-036 SHALL check: div_load int=1 -> cfg_err=1, shadow unchanged (next tx_init still gives the previous period); div_load int=20 -> cfg_err=0.
REQ-037 SHALL check: tx running at 10, div_load int=20 without init -> period stays 10; tx_init with div_load int=30 in the same cycle -> period 30.
REQ-038 SHALL check: tx_en dropped for 7 cycles mid-period -> no tick, count frozen, period resumes and is extended by exactly 7; rst mid-period -> ticks 0, divisor returns to RESET_DIV.

Source files
------------

// File: rtl/baud_gen_frac.sv
// -----------------------------------------------------------------------------
// baud_gen_frac
//   Fractional baud-rate tick generator with two independent channels
//   (tx = channel 0, rx = channel 1).  The bit period of each channel is
//   div_int + div_frac/2^FRAC_W clock cycles on average.  Each period is
//   either the floor or the ceiling of that value.  The fractional part is
//   spread over the periods with a FRAC_W-bit phase accumulator.
//
//   A single shadow divisor is written with div_load.  A channel copies the
//   shadow into its active divisor only when that channel is initialised.
//   This means reprogramming never disturbs a channel that is already running.
//
// Ports
//   clk       in   clock; all logic runs on the rising edge
//   rst       in   synchronous active-high reset
//   div_int   in   integer divisor, in clk cycles per bit (must be >= 2)
//   div_frac  in   fractional divisor, in units of 1/2^FRAC_W cycle
//   div_load  in   strobe that captures div_int/div_frac into the shadow
//   cfg_err   out  sticky flag: the last div_load was rejected
//   tx_init   in   tx channel initialise (phase 0)
//   rx_init   in   rx channel initialise (phase = half a bit)
//   tx_en     in   tx count enable
//   rx_en     in   rx count enable
//   tx_tick   out  registered one-cycle tx bit pulse
//   rx_tick   out  registered one-cycle rx bit pulse
// -----------------------------------------------------------------------------
module baud_gen_frac #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int RESET_DIV  = 868,
    parameter int RESET_FRAC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              cfg_err,
    input  logic              tx_init,
    input  logic              rx_init,
    input  logic              tx_en,
    input  logic              rx_en,
    output logic              tx_tick,
    output logic              rx_tick
);

    localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RESET_DIV);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RESET_FRAC);
    localparam logic [DIV_W-1:0]  MIN_DIV  = DIV_W'(2);
    localparam logic [DIV_W-1:0]  ONE_C    = DIV_W'(1);
    localparam logic [DIV_W:0]    ONE_W    = (DIV_W+1)'(1);

    // ------------------------------------------------------------------
    // Shadow divisor and configuration error flag
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]  shadow_int_q,  shadow_int_d;
    logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
    logic              cfg_err_q,     cfg_err_d;
    logic              load_ok;
    logic [DIV_W-1:0]  init_int;
    logic [FRAC_W-1:0] init_frac;

    assign load_ok = div_load && (div_int >= MIN_DIV);

    // An init in the same cycle as an accepted load takes the new divisor
    // directly, bypassing the shadow register.
    assign init_int  = load_ok ? div_int  : shadow_int_q;
    assign init_frac = load_ok ? div_frac : shadow_frac_q;

    always_comb begin
        shadow_int_d  = shadow_int_q;
        shadow_frac_d = shadow_frac_q;
        cfg_err_d     = cfg_err_q;
        if (div_load) begin
            cfg_err_d = !load_ok;
            if (load_ok) begin
                shadow_int_d  = div_int;
                shadow_frac_d = div_frac;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_int_q  <= RST_INT;
            shadow_frac_q <= RST_FRAC;
            cfg_err_q     <= 1'b0;
        end else begin
            shadow_int_q  <= shadow_int_d;
            shadow_frac_q <= shadow_frac_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    // ------------------------------------------------------------------
    // Per-channel counters: index 0 = tx, index 1 = rx
    // ------------------------------------------------------------------
    logic [1:0] init_w;
    logic [1:0] en_w;
    logic [1:0] tick_w;

    assign init_w = {rx_init, tx_init};
    assign en_w   = {rx_en,   tx_en};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        // The rx channel starts half a bit in, so that it samples mid-bit.
        localparam bit HALF_START = (gi == 1);

        logic [DIV_W-1:0]  count_q, count_d;
        logic [FRAC_W-1:0] acc_q,   acc_d;
        logic [DIV_W-1:0]  int_q,   int_d;
        logic [FRAC_W-1:0] frac_q,  frac_d;
        logic              tick_q,  tick_d;
        logic [FRAC_W:0]   frac_sum;
        logic [DIV_W:0]    last_cnt;
        logic              wrap;

        always_comb begin
            // The carry out of acc+frac stretches this period by one cycle.
            frac_sum = {1'b0, acc_q} + {1'b0, frac_q};
            last_cnt = {1'b0, int_q} + {{DIV_W{1'b0}}, frac_sum[FRAC_W]} - ONE_W;
            // A count beyond the last value also wraps, so the channel
            // recovers if it is ever in an unexpected state.
            wrap     = ({1'b0, count_q} >= last_cnt);

            count_d = count_q;
            acc_d   = acc_q;
            int_d   = int_q;
            frac_d  = frac_q;
            tick_d  = 1'b0;

            if (init_w[gi]) begin
                int_d   = init_int;
                frac_d  = init_frac;
                acc_d   = '0;
                count_d = HALF_START ? (init_int >> 1) : '0;
            end else if (en_w[gi]) begin
                if (wrap) begin
                    count_d = '0;
                    acc_d   = frac_sum[FRAC_W-1:0];
                    tick_d  = 1'b1;
                end else begin
                    count_d = count_q + ONE_C;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                count_q <= '0;
                acc_q   <= '0;
                int_q   <= RST_INT;
                frac_q  <= RST_FRAC;
                tick_q  <= 1'b0;
            end else begin
                count_q <= count_d;
                acc_q   <= acc_d;
                int_q   <= int_d;
                frac_q  <= frac_d;
                tick_q  <= tick_d;
            end
        end

        assign tick_w[gi] = tick_q;
    end

    assign tx_tick = tick_w[0];
    assign rx_tick = tick_w[1];

endmodule

// File: tb/tb_baud_gen_frac.sv
// -----------------------------------------------------------------------------
// tb_baud_gen_frac
//   Self-checking bench for baud_gen_frac.  The reference model predicts tick
//   times arithmetically.  After an init, the n-th tick of a channel falls on
//   enabled cycle n*int + floor(n*frac/2^FRAC_W) - offset.  The offset is 0
//   for tx and int/2 for rx.  Directed steps also measure tick spacing
//   against fixed expected periods.
// -----------------------------------------------------------------------------
module tb_baud_gen_frac;
    localparam int DIV_W      = 16;
    localparam int FRAC_W     = 4;
    localparam int RESET_DIV  = 868;
    localparam int RESET_FRAC = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              cfg_err;
    logic              tx_init, rx_init, tx_en, rx_en;
    logic              tx_tick, rx_tick;

    baud_gen_frac #(
        .DIV_W      (DIV_W),
        .FRAC_W     (FRAC_W),
        .RESET_DIV  (RESET_DIV),
        .RESET_FRAC (RESET_FRAC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .cfg_err  (cfg_err),
        .tx_init  (tx_init),
        .rx_init  (rx_init),
        .tx_en    (tx_en),
        .rx_en    (rx_en),
        .tx_tick  (tx_tick),
        .rx_tick  (rx_tick)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    // Reference model state
    longint sh_int, sh_frac;
    bit     m_cfg;
    longint a_int [2];
    longint a_frac[2];
    longint e_cnt [2];
    longint n_idx [2];
    longint off   [2];
    bit     m_tick[2];

    // Observed tick cycle numbers
    longint tx_q[$];
    longint rx_q[$];

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input bit r, input bit ti, input bit te, input bit ri, input bit re,
                        input bit dl, input longint di, input longint df);
        bit     ok;
        longint ni, nf, due;
        bit     ini[2];
        bit     en [2];
        rst      = r;
        tx_init  = ti;
        tx_en    = te;
        rx_init  = ri;
        rx_en    = re;
        div_load = dl;
        div_int  = DIV_W'(di);
        div_frac = FRAC_W'(df);
        @(posedge clk);
        cyc++;
        ini[0] = ti; ini[1] = ri;
        en[0]  = te; en[1]  = re;
        if (r) begin
            sh_int  = RESET_DIV;
            sh_frac = RESET_FRAC;
            m_cfg   = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                a_int[ch]  = RESET_DIV;
                a_frac[ch] = RESET_FRAC;
                e_cnt[ch]  = 0;
                n_idx[ch]  = 1;
                off[ch]    = 0;
                m_tick[ch] = 1'b0;
            end
        end else begin
            ok = dl && (di >= 2);
            ni = ok ? di : sh_int;
            nf = ok ? df : sh_frac;
            if (dl) begin
                m_cfg = !ok;
                if (ok) begin
                    sh_int  = di;
                    sh_frac = df;
                end
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (ini[ch]) begin
                    a_int[ch]  = ni;
                    a_frac[ch] = nf;
                    e_cnt[ch]  = 0;
                    n_idx[ch]  = 1;
                    off[ch]    = (ch == 1) ? ni / 2 : 0;
                    m_tick[ch] = 1'b0;
                end else if (en[ch]) begin
                    e_cnt[ch]++;
                    due = n_idx[ch] * a_int[ch] + (n_idx[ch] * a_frac[ch]) / (1 << FRAC_W) - off[ch];
                    if (e_cnt[ch] == due) begin
                        m_tick[ch] = 1'b1;
                        n_idx[ch]++;
                    end else begin
                        m_tick[ch] = 1'b0;
                    end
                end else begin
                    m_tick[ch] = 1'b0;
                end
            end
        end
        #1;
        chk("tx_tick", longint'(tx_tick), longint'(m_tick[0]));
        chk("rx_tick", longint'(rx_tick), longint'(m_tick[1]));
        chk("cfg_err", longint'(cfg_err), longint'(m_cfg));
        if (tx_tick === 1'b1) tx_q.push_back(cyc);
        if (rx_tick === 1'b1) rx_q.push_back(cyc);
    endtask

    task automatic run(input bit te, input bit re, input int nc);
        repeat (nc) step(0, 0, te, 0, re, 0, 0, 0);
    endtask

    // Step with one channel enabled until it has produced 'target' ticks or
    // the cycle budget expires; an expired budget shows up as a count check.
    task automatic wait_ticks(input int ch, input int target, input int maxc);
        int k = 0;
        while (((ch == 0) ? tx_q.size() : rx_q.size()) < target && k < maxc) begin
            step(0, 0, ch == 0, 0, ch == 1, 0, 0, 0);
            k++;
        end
        chk(ch == 0 ? "tx_tick_count" : "rx_tick_count",
            (ch == 0) ? tx_q.size() : rx_q.size(), target);
    endtask

    initial begin
        longint ci, prev, rc;

        // Reset
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_tx_tick", tx_tick, 0);

        // Integer divisor 10 on tx
        step(0, 0, 0, 0, 0, 1, 10, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        ci = cyc; tx_q.delete();
        wait_ticks(0, 3, 40);
        chk("int10_first", tx_q[0] - ci, 10);
        chk("int10_p2", tx_q[1] - tx_q[0], 10);
        chk("int10_p3", tx_q[2] - tx_q[1], 10);

        // Fractional divisor 10 + 8/16: periods alternate 10, 11
        step(0, 0, 0, 0, 0, 1, 10, 8);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        ci = cyc; tx_q.delete();
        wait_ticks(0, 32, 400);
        for (int k = 0; k < 32; k++) begin
            prev = (k == 0) ? ci : tx_q[k-1];
            chk("frac_period", tx_q[k] - prev, (k % 2 == 0) ? 10 : 11);
        end
        chk("frac_total", tx_q[31] - ci, 336);

        // rx half-bit start
        step(0, 0, 0, 0, 0, 1, 10, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        ci = cyc; rx_q.delete();
        wait_ticks(1, 3, 50);
        chk("rx_first", rx_q[0] - ci, 5);
        chk("rx_p2", rx_q[1] - rx_q[0], 10);
        chk("rx_p3", rx_q[2] - rx_q[1], 10);

        // Rejected load keeps the shadow; good load clears the error
        step(0, 0, 0, 0, 0, 1, 1, 3);
        chk("bad_load_err", cfg_err, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        ci = cyc; tx_q.delete();
        wait_ticks(0, 1, 30);
        chk("bad_load_period", tx_q[0] - ci, 10);
        step(0, 0, 0, 0, 0, 1, 20, 0);
        chk("good_load_err", cfg_err, 0);

        // Running channel ignores a load; init with load-through takes it
        step(0, 0, 0, 0, 0, 1, 10, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        ci = cyc; tx_q.delete();
        wait_ticks(0, 1, 30);
        step(0, 0, 1, 0, 0, 1, 20, 0);
        wait_ticks(0, 3, 40);
        chk("run_load_p2", tx_q[1] - tx_q[0], 10);
        chk("run_load_p3", tx_q[2] - tx_q[1], 10);
        step(0, 1, 1, 0, 0, 1, 30, 0);
        ci = cyc; tx_q.delete();
        wait_ticks(0, 2, 80);
        chk("thru_first", tx_q[0] - ci, 30);
        chk("thru_p2", tx_q[1] - tx_q[0], 30);

        // Enable gap of 7 stretches the period by 7
        step(0, 0, 0, 0, 0, 1, 10, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        ci = cyc; tx_q.delete();
        run(1, 0, 4);
        run(0, 0, 7);
        chk("gap_no_tick", tx_q.size(), 0);
        wait_ticks(0, 2, 40);
        chk("gap_first", tx_q[0] - ci, 17);
        chk("gap_p2", tx_q[1] - tx_q[0], 10);

        // Reset mid-period, competing with init/load/en
        run(1, 1, 3);
        step(1, 1, 1, 1, 1, 1, 5, 3);
        chk("rst_mid_tx", tx_tick, 0);
        chk("rst_mid_rx", rx_tick, 0);
        rc = cyc; tx_q.delete(); rx_q.delete();
        run(1, 1, 870);
        chk("rst_tx_count", tx_q.size(), 1);
        chk("rst_rx_count", rx_q.size(), 1);
        chk("rst_tx_period", tx_q[0] - rc, RESET_DIV);
        chk("rst_rx_period", rx_q[0] - rc, RESET_DIV);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 599) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 29) == 0,
                 longint'($urandom_range(0, 24)),
                 longint'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
